sdrc_wb_arbiter: RTL

//  Round-robin arbiter sharing the single Wishbone slave port of sdrc_top among NUM_M masters.

---
 rtl/sdrc_wb_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sdrc_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the sdrc_top slave port.
// Holds the grant for a whole wb_cyc and aborts stalled accesses with an error after TIMEOUT cycles.
module sdrc_wb_arbiter #(
    parameter int NUM_M   = 2,
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NUM_M-1:0]       m_cyc_i,
    input  logic [NUM_M-1:0]       m_stb_i,
    input  logic [NUM_M-1:0]       m_we_i,
    input  logic [NUM_M*AW-1:0]    m_addr_i,
    input  logic [NUM_M*DW-1:0]    m_dat_i,
    input  logic [NUM_M*DW/8-1:0]  m_sel_i,
    input  logic [NUM_M*3-1:0]     m_cti_i,
    output logic [DW-1:0]          m_dat_o,
    output logic [NUM_M-1:0]       m_ack_o,
    output logic [NUM_M-1:0]       m_err_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [AW-1:0]          s_addr_o,
    output logic [DW-1:0]          s_dat_o,
    output logic [DW/8-1:0]        s_sel_o,
    output logic [2:0]             s_cti_o,
    input  logic [DW-1:0]          s_dat_i,
    input  logic                   s_ack_i,
    output logic [NUM_M-1:0]       grant_o,
    output logic                   busy_o
);

    localparam int          SW     = DW / 8;
    localparam int          IW     = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [15:0] TMO16  = 16'(TIMEOUT);
    localparam logic [15:0] TMAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_FLUSH
    } state_t;

    state_t           state_reg;
    logic [NUM_M-1:0] grant_reg;
    logic [IW-1:0]    idx_reg;
    logic [IW-1:0]    last_reg;
    logic [15:0]      timer_reg;
    logic             busy_reg;

    logic [AW-1:0]    addr_arr [NUM_M];
    logic [DW-1:0]    dat_arr  [NUM_M];
    logic [SW-1:0]    sel_arr  [NUM_M];
    logic [2:0]       cti_arr  [NUM_M];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_unpack
            assign addr_arr[gi] = m_addr_i[gi*AW +: AW];
            assign dat_arr[gi]  = m_dat_i[gi*DW +: DW];
            assign sel_arr[gi]  = m_sel_i[gi*SW +: SW];
            assign cti_arr[gi]  = m_cti_i[gi*3 +: 3];
        end
    endgenerate

    // Round-robin search: scanning offsets from far to near lets the
    // nearest requester after last_reg overwrite any farther one.
    logic          req_any;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;

    always_comb begin
        req_any  = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM_M; k >= 1; k--) begin
            cand = IW'((int'(last_reg) + k) % NUM_M);
            if (m_cyc_i[cand]) begin
                req_any  = 1'b1;
                pick_idx = cand;
            end
        end
    end

    logic in_busy;
    logic sel_cyc;
    logic sel_stb;
    logic ack_fwd;
    logic timeout_hit;

    assign in_busy  = (state_reg == ST_BUSY);
    assign sel_cyc  = m_cyc_i[idx_reg];
    assign sel_stb  = m_stb_i[idx_reg];

    assign s_cyc_o  = in_busy & sel_cyc;
    assign s_stb_o  = in_busy & sel_cyc & sel_stb;
    assign s_we_o   = in_busy & m_we_i[idx_reg];
    assign s_addr_o = in_busy ? addr_arr[idx_reg] : '0;
    assign s_dat_o  = in_busy ? dat_arr[idx_reg]  : '0;
    assign s_sel_o  = in_busy ? sel_arr[idx_reg]  : '0;
    assign s_cti_o  = in_busy ? cti_arr[idx_reg]  : '0;
    assign m_dat_o  = s_dat_i;

    // An ack in the timeout cycle wins, so the error only fires on a stalled strobe.
    assign ack_fwd     = s_cyc_o & s_ack_i;
    assign timeout_hit = s_stb_o & ~s_ack_i & (timer_reg >= TMO16);

    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_resp
            assign m_ack_o[gi] = grant_reg[gi] & ack_fwd;
            assign m_err_o[gi] = grant_reg[gi] & timeout_hit;
        end
    endgenerate

    assign grant_o = grant_reg;
    assign busy_o  = busy_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            timer_reg <= '0;
        end else if (s_ack_i || !s_stb_o) begin
            timer_reg <= '0;
        end else if (timer_reg != TMAX) begin
            timer_reg <= timer_reg + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            idx_reg   <= '0;
            last_reg  <= IW'(NUM_M - 1);
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_any) begin
                        state_reg <= ST_BUSY;
                        grant_reg <= {{(NUM_M-1){1'b0}}, 1'b1} << pick_idx;
                        idx_reg   <= pick_idx;
                        last_reg  <= pick_idx;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (!sel_cyc) begin
                        state_reg <= ST_IDLE;
                        grant_reg <= '0;
                        busy_reg  <= 1'b0;
                    end else if (timeout_hit) begin
                        state_reg <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!sel_cyc) begin
                        state_reg <= ST_IDLE;
                        grant_reg <= '0;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
